// File: rtl/onehot_sel_encoder.sv
// ---------------------------------------------------------------------------
// onehot_sel_encoder
//
// Registered one-hot-to-binary select encoder. A 4-bit select vector is
// accepted over a valid/ready handshake, checked for one-hot legality and
// encoded to the 2-bit code {c,d}. The {c,d,err} result is queued in a
// 2-entry output FIFO. Saturating counters record how many vectors were
// accepted and how many of those were illegal.
//
// Parameters:
//   CNT_W      width of the acc_cnt / err_cnt status counters
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous, active-low reset
//   mux_in     select vector (legal when exactly one bit is set)
//   in_valid   mux_in is valid this cycle
//   in_ready   buffer can accept a vector this cycle (registered state only)
//   c, d       code MSB / LSB of the buffer head entry (0 when empty)
//   out_err    head entry came from an illegal vector (0 when empty)
//   out_valid  head entry is valid
//   out_ready  downstream accepts the head entry
//   acc_cnt    saturating count of accepted vectors
//   err_cnt    saturating count of accepted illegal vectors
// ---------------------------------------------------------------------------
module onehot_sel_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [3:0]       mux_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             c,
  output logic             d,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int DEPTH = 2;

  // Occupancy of the output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             occ_q;
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [2:0]       mem_q [DEPTH];
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       push;
  logic       pop;
  logic [1:0] code_d;
  logic       legal_d;
  logic [2:0] entry_d;
  logic [2:0] head;

  // -------------------------------------------------------------------------
  // Handshake. in_ready depends only on registered occupancy, so a full
  // buffer never accepts in the same cycle it drains.
  // -------------------------------------------------------------------------
  assign in_ready  = (occ_q != FULL);
  assign out_valid = (occ_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // -------------------------------------------------------------------------
  // Encoder. The code is the index of the lowest set bit; an all-zero
  // vector encodes as 00. Scanning from the top down lets the lowest set
  // bit win.
  // -------------------------------------------------------------------------
  always_comb begin
    code_d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mux_in[i]) begin
        code_d = 2'(i);
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign legal_d = (mux_in != 4'd0) && ((mux_in & (mux_in - 4'd1)) == 4'd0);
  assign entry_d = {code_d, ~legal_d};

  // -------------------------------------------------------------------------
  // Buffer storage. Each entry only loads when it is the write target of an
  // accepted push, so mux_in is never sampled while in_valid is low.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!resetn) begin
          mem_q[gi] <= 3'd0;
        end else if (push && (wr_ptr_q == 1'(gi))) begin
          mem_q[gi] <= entry_d;
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Occupancy FSM and pointers. With one entry and a simultaneous push and
  // pop, the old head leaves and the new entry becomes the only (head) one.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      occ_q    <= EMPTY;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case (occ_q)
        EMPTY: begin
          if (push) occ_q <= ONE;
        end
        ONE: begin
          if (push && !pop)      occ_q <= FULL;
          else if (!push && pop) occ_q <= EMPTY;
        end
        FULL: begin
          if (pop) occ_q <= ONE;
        end
        default: occ_q <= EMPTY;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Saturating status counters.
  // -------------------------------------------------------------------------
  always_comb begin
    acc_cnt_d = acc_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push && (acc_cnt_q != {CNT_W{1'b1}})) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
    if (push && !legal_d && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign acc_cnt = acc_cnt_q;
  assign err_cnt = err_cnt_q;

  // -------------------------------------------------------------------------
  // Head presentation, forced to zero while the buffer is empty.
  // -------------------------------------------------------------------------
  assign head    = mem_q[rd_ptr_q];
  assign c       = out_valid & head[2];
  assign d       = out_valid & head[1];
  assign out_err = out_valid & head[0];

endmodule

// File: tb/tb_onehot_sel_encoder.sv
// ---------------------------------------------------------------------------
// Testbench for onehot_sel_encoder. Inputs change 1 ns after each rising
// edge; outputs are sampled at that same point, after the edge has settled.
// ---------------------------------------------------------------------------
module tb_onehot_sel_encoder;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] mux_in;
  logic       in_valid;
  logic       in_ready;
  logic       c, d, out_err, out_valid;
  logic       out_ready;
  logic [7:0] acc_cnt, err_cnt;

  // Small-counter instance used for saturation.
  logic [3:0] s_mux_in;
  logic       s_in_valid, s_in_ready;
  logic       s_c, s_d, s_out_err, s_out_valid;
  logic       s_out_ready;
  logic [2:0] s_acc_cnt, s_err_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_acc = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  onehot_sel_encoder #(.CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .mux_in(mux_in), .in_valid(in_valid),
    .in_ready(in_ready), .c(c), .d(d), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_cnt(acc_cnt), .err_cnt(err_cnt)
  );

  onehot_sel_encoder #(.CNT_W(3)) dut_s (
    .clk(clk), .resetn(resetn), .mux_in(s_mux_in), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .c(s_c), .d(s_d), .out_err(s_out_err),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .acc_cnt(s_acc_cnt), .err_cnt(s_err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference encoding {c,d,err}: lowest set bit index, err unless one-hot.
  function automatic logic [2:0] ref_enc(input logic [3:0] v);
    logic [1:0] code;
    code = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        code = 2'(i);
        break;
      end
    end
    return {code, ($countones(v) != 1)};
  endfunction

  function automatic logic [2:0] head3();
    return {c, d, out_err};
  endfunction

  initial begin
    logic [3:0] legal_v  [4];
    logic [2:0] legal_e  [4];
    logic [3:0] illegal_v[4];
    logic [2:0] illegal_e[4];
    logic [2:0] sb_q[$];
    logic [3:0] v;
    logic       pushed, popped;

    legal_v   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    legal_e   = '{3'b000, 3'b010, 3'b100, 3'b110};
    illegal_v = '{4'b0000, 4'b0110, 4'b1100, 4'b1111};
    illegal_e = '{3'b001, 3'b011, 3'b101, 3'b001};

    resetn = 1'b0; mux_in = 4'd0; in_valid = 1'b0; out_ready = 1'b0;
    s_mux_in = 4'd0; s_in_valid = 1'b0; s_out_ready = 1'b1;

    // ---- Reset ----
    step(); step();
    $display("[TB] reset applied");
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_head", head3(), 3'b000);
    check_eq("rst_acc", acc_cnt, 8'd0);
    check_eq("rst_err", err_cnt, 8'd0);
    resetn = 1'b1;

    // ---- Legal sweep, back-to-back with out_ready high ----
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("legal_in_ready", in_ready, 1'b1);
      in_valid = 1'b1; mux_in = legal_v[i];
      step();
      $display("[TB] legal push %b -> %b", legal_v[i], head3());
      check_eq("legal_valid", out_valid, 1'b1);
      check_eq("legal_head", head3(), legal_e[i]);
    end
    in_valid = 1'b0;
    step();
    check_eq("legal_drain", out_valid, 1'b0);
    check_eq("legal_acc", acc_cnt, 8'd4);
    check_eq("legal_err", err_cnt, 8'd0);

    // ---- Illegal vectors ----
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; mux_in = illegal_v[i];
      step();
      $display("[TB] illegal push %b -> %b", illegal_v[i], head3());
      check_eq("illegal_head", head3(), illegal_e[i]);
    end
    in_valid = 1'b0;
    step();
    check_eq("illegal_acc", acc_cnt, 8'd8);
    check_eq("illegal_err", err_cnt, 8'd4);

    // ---- Idle input with X must not change state ----
    mux_in = 4'bxxxx;
    step(); step();
    check_eq("x_out_valid", out_valid, 1'b0);
    check_eq("x_acc", acc_cnt, 8'd8);
    check_eq("x_err", err_cnt, 8'd4);

    // ---- Backpressure ----
    out_ready = 1'b0;
    in_valid = 1'b1; mux_in = 4'b0010;
    step();
    check_eq("bp_in_ready_one", in_ready, 1'b1);
    mux_in = 4'b1000;
    step();
    $display("[TB] backpressure: two pushes held");
    check_eq("bp_in_ready_full", in_ready, 1'b0);
    check_eq("bp_head_full", head3(), 3'b010);
    mux_in = 4'b0100;
    step();
    check_eq("bp_in_ready_hold", in_ready, 1'b0);
    check_eq("bp_head_stall", head3(), 3'b010);
    check_eq("bp_acc_hold", acc_cnt, 8'd10);
    out_ready = 1'b1;
    step();
    $display("[TB] backpressure: first pop");
    check_eq("bp_in_ready_after_pop", in_ready, 1'b1);
    check_eq("bp_head_2nd", head3(), 3'b110);
    check_eq("bp_acc_no_push", acc_cnt, 8'd10);
    step();
    $display("[TB] backpressure: third offer accepted");
    check_eq("bp_head_3rd", head3(), 3'b100);
    check_eq("bp_acc_third", acc_cnt, 8'd11);
    in_valid = 1'b0;
    step();
    check_eq("bp_drain", out_valid, 1'b0);

    // ---- Streaming scoreboard: 100 random vectors, out_ready high ----
    exp_acc = 11; exp_err = 4;
    for (int n = 0; n < 100; n++) begin
      v = 4'($urandom_range(0, 15));
      in_valid = 1'b1; mux_in = v;
      pushed = in_valid && in_ready;
      popped = out_valid && out_ready;
      step();
      if (popped) void'(sb_q.pop_front());
      if (pushed) begin
        sb_q.push_back(ref_enc(v));
        if (exp_acc < 255) exp_acc++;
        if (ref_enc(v) & 3'b001) begin
          if (exp_err < 255) exp_err++;
        end
      end
      check_eq("sb_in_ready", in_ready, 1'b1);
      check_eq("sb_depth", sb_q.size(), 1);
      if (sb_q.size() != 0) check_eq("sb_head", head3(), sb_q[0]);
    end
    in_valid = 1'b0;
    step();
    $display("[TB] stream done, acc=%0d err=%0d", acc_cnt, err_cnt);
    check_eq("sb_drain", out_valid, 1'b0);
    check_eq("sb_acc", acc_cnt, exp_acc);
    check_eq("sb_err", err_cnt, exp_err);

    // ---- Saturation on the CNT_W=3 instance ----
    s_in_valid = 1'b1; s_mux_in = 4'b0000;
    for (int n = 0; n < 10; n++) begin
      step();
    end
    $display("[TB] saturation: acc=%0d err=%0d", s_acc_cnt, s_err_cnt);
    check_eq("sat_acc", s_acc_cnt, 3'd7);
    check_eq("sat_err", s_err_cnt, 3'd7);
    s_mux_in = 4'b1001;
    step(); step();
    check_eq("sat_acc_hold", s_acc_cnt, 3'd7);
    check_eq("sat_err_hold", s_err_cnt, 3'd7);
    s_in_valid = 1'b0;

    // ---- Reset mid-operation ----
    out_ready = 1'b0;
    in_valid = 1'b1; mux_in = 4'b0001;
    step();
    mux_in = 4'b0010;
    step();
    check_eq("mr_full", in_ready, 1'b0);
    in_valid = 1'b0; resetn = 1'b0;
    step();
    $display("[TB] mid-operation reset");
    check_eq("mr_out_valid", out_valid, 1'b0);
    check_eq("mr_in_ready", in_ready, 1'b1);
    check_eq("mr_head", head3(), 3'b000);
    check_eq("mr_acc", acc_cnt, 8'd0);
    check_eq("mr_err", err_cnt, 8'd0);
    resetn = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; mux_in = 4'b0100;
    step();
    in_valid = 1'b0;
    check_eq("mr_push_valid", out_valid, 1'b1);
    check_eq("mr_push_head", head3(), 3'b100);
    check_eq("mr_push_acc", acc_cnt, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
